// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types, defaults and pass-selection helper for the scan sequencer
package scan_pkg;

    localparam int IMG_W_DEF  = 150;
    localparam int IMG_H_DEF  = 150;
    localparam int ADDR_W_DEF = 15;

    typedef enum logic [1:0] {
        PASS_LR = 2'd0,
        PASS_UD = 2'd1,
        PASS_DL = 2'd2,
        PASS_DR = 2'd3
    } pass_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Returns {found, pass}: the lowest enabled pass whose index is >= from.
    function automatic logic [2:0] first_pass(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - pixel-address beat stream between sequencer and fetch datapath
interface scan_sequencer_if #(
    parameter int ADDR_W = 15
);
    logic              addr_valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              line_start;
    logic              line_end;
    logic [1:0]        pass_mode;

    modport master (
        output addr_valid, addr, line_start, line_end, pass_mode,
        input  ready
    );

    modport slave (
        input  addr_valid, addr, line_start, line_end, pass_mode,
        output ready
    );
endinterface

// File: rtl/diag_walker.sv
// rtl/diag_walker.sv - row/column/address walker for one scan line of any pass type
module diag_walker
    import scan_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CW     = 8,
    parameter int LW     = 9
)(
    input  logic              clk,
    input  logic              resetIn,
    input  logic              load,
    input  logic              step,
    input  pass_e             load_pass,
    input  logic [LW-1:0]     load_line,
    output logic [ADDR_W-1:0] addr,
    output logic              last_in_line
);
    localparam logic [LW-1:0]     WM1_L   = LW'(IMG_W - 1);
    localparam logic [CW-1:0]     W_MAX   = CW'(IMG_W - 1);
    localparam logic [CW-1:0]     H_MAX   = CW'(IMG_H - 1);
    localparam logic [CW-1:0]     ONE_C   = CW'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] STEP_DL = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] STEP_DR = ADDR_W'(IMG_W + 1);

    pass_e         pass_q;
    logic [CW-1:0] r, c, r0, c0;

    // Line start point; diagonals past the top-row corner begin on the edge column.
    always_comb begin
        r0 = '0;
        c0 = '0;
        case (load_pass)
            PASS_LR: r0 = CW'(load_line);
            PASS_UD: c0 = CW'(load_line);
            PASS_DL: begin
                r0 = (load_line > WM1_L) ? CW'(load_line - WM1_L) : '0;
                c0 = (load_line > WM1_L) ? W_MAX : CW'(load_line);
            end
            default: begin
                r0 = (load_line > WM1_L) ? CW'(load_line - WM1_L) : '0;
                c0 = (load_line > WM1_L) ? '0 : CW'(WM1_L - load_line);
            end
        endcase
    end

    always_comb begin
        case (pass_q)
            PASS_LR: last_in_line = (c == W_MAX);
            PASS_UD: last_in_line = (r == H_MAX);
            PASS_DL: last_in_line = (r == H_MAX) || (c == '0);
            default: last_in_line = (r == H_MAX) || (c == W_MAX);
        endcase
    end

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            pass_q <= PASS_LR;
            r      <= '0;
            c      <= '0;
            addr   <= '0;
        end else if (load) begin
            pass_q <= load_pass;
            r      <= r0;
            c      <= c0;
            addr   <= ADDR_W'(r0) * W_A + ADDR_W'(c0);
        end else if (step) begin
            case (pass_q)
                PASS_LR: begin
                    c    <= c + ONE_C;
                    addr <= addr + ONE_A;
                end
                PASS_UD: begin
                    r    <= r + ONE_C;
                    addr <= addr + W_A;
                end
                PASS_DL: begin
                    r    <= r + ONE_C;
                    c    <= c - ONE_C;
                    addr <= addr + STEP_DL;
                end
                default: begin
                    r    <= r + ONE_C;
                    c    <= c + ONE_C;
                    addr <= addr + STEP_DR;
                end
            endcase
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - FSM sequencing LR/UD/DL/DR edge-detection scans over the image
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic             clk,
    input  logic             resetIn,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       pass_mask,
    output logic             busy,
    output logic             done,
    scan_sequencer_if.master beat
);
    localparam int CW = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H);
    localparam int LW = $clog2(IMG_W + IMG_H - 1);
    localparam logic [LW-1:0] ONE_L     = LW'(1);
    localparam logic [LW-1:0] LAST_LR   = LW'(IMG_H - 1);
    localparam logic [LW-1:0] LAST_UD   = LW'(IMG_W - 1);
    localparam logic [LW-1:0] LAST_DIAG = LW'(IMG_W + IMG_H - 2);

    state_e        state, state_n;
    pass_e         pass_q, pass_n;
    logic [3:0]    mask_q, mask_n;
    logic [LW-1:0] line_q, line_n, last_line;
    logic          first_q, first_n;
    logic          load, step, scan, accept, last_in_line;
    logic [2:0]    sel;
    logic [ADDR_W-1:0] walk_addr;

    assign scan   = (state == ST_SCAN);
    assign accept = scan && beat.ready;

    always_comb begin
        case (pass_q)
            PASS_LR: last_line = LAST_LR;
            PASS_UD: last_line = LAST_UD;
            default: last_line = LAST_DIAG;
        endcase
    end

    always_comb begin
        state_n = state;
        pass_n  = pass_q;
        mask_n  = mask_q;
        line_n  = line_q;
        first_n = first_q;
        load    = 1'b0;
        step    = 1'b0;
        sel     = 3'b000;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    mask_n = pass_mask;
                    sel    = first_pass(pass_mask, 3'd0);
                    if (sel[2]) begin
                        state_n = ST_SCAN;
                        pass_n  = pass_e'(sel[1:0]);
                        line_n  = '0;
                        load    = 1'b1;
                        first_n = 1'b1;
                    end else begin
                        state_n = ST_FIN;
                    end
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (accept) begin
                    first_n = 1'b0;
                    if (!last_in_line) begin
                        step = 1'b1;
                    end else if (line_q != last_line) begin
                        line_n  = line_q + ONE_L;
                        load    = 1'b1;
                        first_n = 1'b1;
                    end else begin
                        // End of pass: hop straight to the next enabled pass without a bubble.
                        sel = first_pass(mask_q, {1'b0, pass_q} + 3'd1);
                        if (sel[2]) begin
                            pass_n  = pass_e'(sel[1:0]);
                            line_n  = '0;
                            load    = 1'b1;
                            first_n = 1'b1;
                        end else begin
                            state_n = ST_FIN;
                        end
                    end
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            state   <= ST_IDLE;
            pass_q  <= PASS_LR;
            mask_q  <= '0;
            line_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state   <= state_n;
            pass_q  <= pass_n;
            mask_q  <= mask_n;
            line_q  <= line_n;
            first_q <= first_n;
        end
    end

    diag_walker #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .CW     (CW),
        .LW     (LW)
    ) u_walker (
        .clk          (clk),
        .resetIn      (resetIn),
        .load         (load),
        .step         (step),
        .load_pass    (pass_n),
        .load_line    (line_n),
        .addr         (walk_addr),
        .last_in_line (last_in_line)
    );

    assign beat.addr_valid = scan;
    assign beat.addr       = walk_addr;
    assign beat.line_start = scan && first_q;
    assign beat.line_end   = scan && last_in_line;
    assign beat.pass_mode  = pass_q;
    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_FIN);

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - self-checking bench for scan_sequencer
module tb_scan_sequencer;
    localparam int W  = 150;
    localparam int H  = 150;
    localparam int AW = 15;

    typedef struct {
        int addr;
        bit ls;
        bit le;
        int pm;
    } beat_t;

    typedef struct {
        logic [3:0] mask;
        int         n;
        int         addr;
        bit         ls;
        bit         le;
        int         pm;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetIn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pass_mask = '0;
    logic       busy, done;

    int    tests = 0, fails = 0;
    int    acc_cnt = 0, ls_cnt = 0, bubbles = 0;
    bit    sb_en = 0, chk_stall = 0, stalled = 0;
    logic [63:0] snap;
    beat_t sbq[$];
    beat_t e;

    scan_sequencer_if #(.ADDR_W(AW)) beat ();

    scan_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk       (clk),
        .resetIn   (resetIn),
        .start     (start),
        .abort     (abort),
        .pass_mask (pass_mask),
        .busy      (busy),
        .done      (done),
        .beat      (beat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cur_vec();
        return 64'({beat.addr_valid, beat.pass_mode, beat.line_start, beat.line_end, beat.addr});
    endfunction

    function automatic logic [63:0] mk_vec(input int pm, input bit ls, input bit le, input int addr);
        return 64'({1'b1, 2'(pm), ls, le, AW'(addr)});
    endfunction

    // Reference beat list built from the coordinate definitions, address = r*W + c.
    task automatic push_model(input logic [3:0] m);
        int nl, r, c;
        bit first, last, fin;
        for (int p = 0; p < 4; p++) begin
            if (m[p]) begin
                nl = (p == 0) ? H : (p == 1) ? W : W + H - 1;
                for (int l = 0; l < nl; l++) begin
                    case (p)
                        0: begin r = l; c = 0; end
                        1: begin r = 0; c = l; end
                        2: begin r = (l > W - 1) ? l - W + 1 : 0; c = (l < W - 1) ? l : W - 1; end
                        default: begin r = (l > W - 1) ? l - W + 1 : 0; c = (W - 1 - l > 0) ? W - 1 - l : 0; end
                    endcase
                    first = 1;
                    fin = 0;
                    while (!fin) begin
                        case (p)
                            0: last = (c == W - 1);
                            1: last = (r == H - 1);
                            2: last = (r == H - 1) || (c == 0);
                            default: last = (r == H - 1) || (c == W - 1);
                        endcase
                        sbq.push_back('{r * W + c, first, last, p});
                        fin = last;
                        first = 0;
                        case (p)
                            0: c++;
                            1: r++;
                            2: begin r++; c--; end
                            default: begin r++; c++; end
                        endcase
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] m, input bit with_abort);
        pass_mask = m;
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        pass_mask = ~m;
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 30000 && acc_cnt < n; k++) tick();
        check($sformatf("reach_beat%0d", n), 64'(acc_cnt), 64'(n));
    endtask

    always @(negedge clk) begin
        if (beat.addr_valid === 1'b1 && beat.ready === 1'b1) begin
            if (sb_en) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got addr %0d, expected no further beat", beat.addr);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("beat%0d", acc_cnt), cur_vec(), mk_vec(e.pm, e.ls, e.le, e.addr));
                end
            end
            acc_cnt++;
            if (beat.line_start) ls_cnt++;
        end
        if (chk_stall && stalled) check("stall_hold", cur_vec(), snap);
        stalled = beat.addr_valid && !beat.ready;
        snap = cur_vec();
        if (busy && !beat.addr_valid && !done) bubbles++;
    end

    initial begin
        vec_t vecs[$];
        int   exp_n, cyc;
        beat.ready = 1'b0;

        vecs.push_back('{4'b0001,   0,     0, 1'b1, 1'b0, 0});
        vecs.push_back('{4'b0001, 149,   149, 1'b0, 1'b1, 0});
        vecs.push_back('{4'b0001, 150,   150, 1'b1, 1'b0, 0});
        vecs.push_back('{4'b0010,   0,     0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0010,   1,   150, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0010, 149, 22350, 1'b0, 1'b1, 1});
        vecs.push_back('{4'b0010, 150,     1, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0100,   0,     0, 1'b1, 1'b1, 2});
        vecs.push_back('{4'b0100,   1,     1, 1'b1, 1'b0, 2});
        vecs.push_back('{4'b0100,   2,   150, 1'b0, 1'b1, 2});
        vecs.push_back('{4'b0100,   3,     2, 1'b1, 1'b0, 2});
        vecs.push_back('{4'b0100,   4,   151, 1'b0, 1'b0, 2});
        vecs.push_back('{4'b0100,   5,   300, 1'b0, 1'b1, 2});
        vecs.push_back('{4'b1000,   0,   149, 1'b1, 1'b1, 3});
        vecs.push_back('{4'b1000,   1,   148, 1'b1, 1'b0, 3});
        vecs.push_back('{4'b1000,   2,   299, 1'b0, 1'b1, 3});
        vecs.push_back('{4'b0110,   0,     0, 1'b1, 1'b0, 1});

        #12;
        check("rst_valid", 64'(beat.addr_valid), 64'(0));
        check("rst_addr", 64'(beat.addr), 64'(0));
        check("rst_flags", 64'({beat.line_start, beat.line_end}), 64'(0));
        check("rst_pass", 64'(beat.pass_mode), 64'(0));
        check("rst_busy_done", 64'({busy, done}), 64'(0));
        resetIn = 1'b1;
        tick();

        beat.ready = 1'b1;
        foreach (vecs[i]) begin
            acc_cnt = 0;
            do_start(vecs[i].mask, 1'b0);
            wait_beats(vecs[i].n);
            check($sformatf("vec%0d", i), cur_vec(), mk_vec(vecs[i].pm, vecs[i].ls, vecs[i].le, vecs[i].addr));
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check($sformatf("vec%0d_abort_idle", i), 64'({busy, done, beat.addr_valid}), 64'(0));
        end

        do_start(4'b0000, 1'b0);
        check("mask0_fin", 64'({busy, done, beat.addr_valid}), 64'(3'b110));
        tick();
        check("mask0_idle", 64'({busy, done}), 64'(0));

        // Full DL+DR scan with random stalls against the reference model.
        sbq.delete();
        push_model(4'b1100);
        exp_n = sbq.size();
        acc_cnt = 0; ls_cnt = 0; bubbles = 0;
        sb_en = 1; chk_stall = 1;
        do_start(4'b1100, 1'b0);
        check("full_first_valid", 64'(beat.addr_valid), 64'(1));
        cyc = 0;
        while (sbq.size() != 0 && cyc < 80000) begin
            beat.ready = ($urandom_range(0, 99) < 85);
            tick();
            cyc++;
        end
        check("full_done", 64'({busy, done, beat.addr_valid}), 64'(3'b110));
        tick();
        check("full_idle", 64'({busy, done}), 64'(0));
        check("full_beats", 64'(acc_cnt), 64'(exp_n));
        check("full_beats_spec", 64'(acc_cnt), 64'(45000));
        check("full_lines", 64'(ls_cnt), 64'(598));
        check("full_bubbles", 64'(bubbles), 64'(0));
        sb_en = 0; chk_stall = 0;

        // Abort at beat 500; start together with abort in IDLE must win; start while busy ignored.
        sbq.delete();
        push_model(4'b0001);
        acc_cnt = 0;
        sb_en = 1;
        beat.ready = 1'b1;
        do_start(4'b0001, 1'b1);
        check("start_beats_abort", 64'({busy, beat.addr_valid}), 64'(2'b11));
        wait_beats(300);
        pass_mask = 4'b1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beats(500);
        check("abort_beat", cur_vec(), mk_vec(0, 0, 0, 500));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb_en = 0;
        check("abort_idle", 64'({busy, done, beat.addr_valid}), 64'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("abort_nodone%0d", k), 64'({busy, done}), 64'(0));
        end

        // Asynchronous reset in the middle of a DR scan.
        acc_cnt = 0;
        do_start(4'b1000, 1'b0);
        wait_beats(200);
        check("pre_reset_active", 64'({busy, beat.addr_valid, beat.pass_mode}), 64'(4'b1111));
        #2;
        resetIn = 1'b0;
        #1;
        check("midrst_stream", cur_vec(), 64'(0));
        check("midrst_busy_done", 64'({busy, done}), 64'(0));
        @(posedge clk);
        #1;
        resetIn = 1'b1;
        tick();
        tick();
        check("post_reset_idle", 64'({busy, beat.addr_valid}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
